// File: rtl/leaf_dispatch_rr.sv
// rtl/leaf_dispatch_rr.sv - single-slot round-robin dispatcher feeding NUM_LANES leaf lanes
//
// Purpose: accepts one payload at a time from upstream into a holding register
// and offers it to exactly one downstream lane. The targeted lane rotates by one
// after every completed dispatch. A saturating counter tracks completed dispatches.
// A second saturating counter tracks how long the targeted lane has refused the pending payload.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    upstream payload valid
//   in_ready    block can take the upstream payload this cycle
//   in_data     upstream payload
//   out_valid   one-hot lane valid (bit lane_sel while a payload is held)
//   out_ready   per-lane ready; only the targeted bit is looked at
//   out_data    shared payload bus
//   lane_sel    index of the lane currently targeted
//   disp_cnt    completed dispatches, saturating at 16'hFFFF
//   stall_flag  targeted lane has been blocked for STALL_LIM or more cycles
module leaf_dispatch_rr #(
    parameter int NUM_LANES = 15,
    parameter int DATA_W    = 32,
    parameter int STALL_LIM = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [3:0]           lane_sel,
    output logic [15:0]          disp_cnt,
    output logic                 stall_flag
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam int             SW        = (STALL_LIM < 1) ? 1 : $clog2(STALL_LIM + 1);
    localparam logic [SW-1:0]  STALL_MAX = SW'(STALL_LIM);
    localparam logic [3:0]     LAST_LANE = 4'(NUM_LANES - 1);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        lane_q, lane_d;
    logic [15:0]       disp_cnt_q, disp_cnt_d;
    logic [SW-1:0]     stall_q, stall_d;

    logic full;
    logic lane_ready;
    logic in_fire;
    logic out_fire;

    assign full       = (state_q == ST_HOLD);
    assign lane_ready = out_ready[lane_q];
    assign out_fire   = full && lane_ready;
    // A slot freed by a dispatch on this edge can be refilled on the same edge.
    assign in_ready   = !full || out_fire;
    assign in_fire    = in_valid && in_ready;

    // out_valid is a function of registered state only, never of out_ready.
    always_comb begin
        out_valid = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            out_valid[i] = full && (lane_q == 4'(i));
        end
    end

    assign out_data   = data_q;
    assign lane_sel   = lane_q;
    assign disp_cnt   = disp_cnt_q;
    assign stall_flag = (stall_q == STALL_MAX);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        lane_d     = lane_q;
        disp_cnt_d = disp_cnt_q;
        stall_d    = stall_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_fire && !in_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Payload register only loads on acceptance, so the presented data stays
        // stable for the whole time it is pending.
        if (in_fire) begin
            data_d = in_data;
        end

        if (out_fire) begin
            lane_d = (lane_q == LAST_LANE) ? 4'd0 : lane_q + 4'd1;
            if (disp_cnt_q != 16'hFFFF) begin
                disp_cnt_d = disp_cnt_q + 16'd1;
            end
        end

        // Stall tracking is purely informational; it never redirects the payload.
        if (!full || out_fire) begin
            stall_d = '0;
        end else if (stall_q != STALL_MAX) begin
            stall_d = stall_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            lane_q     <= 4'd0;
            disp_cnt_q <= 16'd0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            lane_q     <= lane_d;
            disp_cnt_q <= disp_cnt_d;
            stall_q    <= stall_d;
        end
    end

endmodule
